// File: rtl/ps2_mouse_rx_if.sv
// Signal bundle between the raw PS/2 lines, the mouse receiver and the
// menu/game controller that consumes cursor position and buttons.
interface ps2_mouse_rx_if;
    logic        ps2_clk;
    logic        ps2_data;
    logic [11:0] xpos;
    logic [11:0] ypos;
    logic        mouse_left;
    logic        mouse_right;
    logic        pkt_valid;
    logic        err;

    modport master (
        output ps2_clk, ps2_data,
        input  xpos, ypos, mouse_left, mouse_right, pkt_valid, err
    );

    modport slave (
        input  ps2_clk, ps2_data,
        output xpos, ypos, mouse_left, mouse_right, pkt_valid, err
    );
endinterface

// File: rtl/ps2_mouse_rx.sv
// Receive-only PS/2 mouse front end: deframes device bytes, assembles 3-byte
// packets and keeps a clamped absolute cursor position plus button state.
module ps2_mouse_rx #(
    parameter int XMAX    = 1023,
    parameter int YMAX    = 767,
    parameter int X_INIT  = 512,
    parameter int Y_INIT  = 384,
    parameter int TIMEOUT = 65000
) (
    input  logic          clk,
    input  logic          rst,
    ps2_mouse_rx_if.slave bus
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [11:0] XMAX_C   = 12'(XMAX);
    localparam logic [11:0] YMAX_C   = 12'(YMAX);
    localparam logic [11:0] X_INIT_C = 12'(X_INIT);
    localparam logic [11:0] Y_INIT_C = 12'(Y_INIT);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        F_IDLE   = 2'd0,
        F_DATA   = 2'd1,
        F_PARITY = 2'd2,
        F_STOP   = 2'd3
    } frame_state_t;

    typedef enum logic [1:0] {
        P_B0 = 2'd0,
        P_B1 = 2'd1,
        P_B2 = 2'd2
    } pkt_state_t;

    function automatic logic frame_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

    // An overflowing axis contributes no motion at all.
    function automatic logic signed [12:0] sext_delta(input logic sign, input logic ovf,
                                                      input logic [7:0] mag);
        logic signed [12:0] r;
        if (ovf) r = 13'sd0;
        else     r = $signed({{5{sign}}, mag});
        return r;
    endfunction

    function automatic logic [11:0] clamp_axis(input logic signed [12:0] v,
                                               input logic [11:0] vmax);
        logic [11:0] r;
        if (v < 13'sd0)                       r = 12'd0;
        else if (v > $signed({1'b0, vmax}))   r = vmax;
        else                                  r = v[11:0];
        return r;
    endfunction

    logic ps2_clk_meta_r, ps2_clk_sync_r, ps2_clk_prev_r;
    logic ps2_data_meta_r, ps2_data_sync_r;
    logic fall_r, bit_r;

    frame_state_t frame_state_r, frame_state_s;
    pkt_state_t   pkt_state_r, pkt_state_s;
    logic [7:0]    shift_r, shift_s;
    logic [2:0]    bit_cnt_r, bit_cnt_s;
    logic          par_r, par_s;
    logic [5:0]    status_r, status_s;   // {yovf, xovf, ysign, xsign, right, left}
    logic [7:0]    dx_r, dx_s;
    logic [TW-1:0] tmo_cnt_r, tmo_cnt_s;
    logic [11:0]   xpos_r, xpos_s, ypos_r, ypos_s;
    logic          left_r, left_s, right_r, right_s;
    logic          pkt_valid_r, pkt_valid_s, err_r, err_s;
    logic signed [12:0] nx_s, ny_s;

    // Synchronize raw PS/2 lines and register the falling edge with its data bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ps2_clk_meta_r  <= 1'b1;
            ps2_clk_sync_r  <= 1'b1;
            ps2_clk_prev_r  <= 1'b1;
            ps2_data_meta_r <= 1'b1;
            ps2_data_sync_r <= 1'b1;
            fall_r          <= 1'b0;
            bit_r           <= 1'b1;
        end else begin
            ps2_clk_meta_r  <= bus.ps2_clk;
            ps2_clk_sync_r  <= ps2_clk_meta_r;
            ps2_clk_prev_r  <= ps2_clk_sync_r;
            ps2_data_meta_r <= bus.ps2_data;
            ps2_data_sync_r <= ps2_data_meta_r;
            fall_r          <= ps2_clk_prev_r & ~ps2_clk_sync_r;
            bit_r           <= ps2_data_sync_r;
        end
    end

    // Next-state logic for the frame and packet FSMs, timeout and cursor update.
    always_comb begin
        frame_state_s = frame_state_r;
        pkt_state_s   = pkt_state_r;
        shift_s       = shift_r;
        bit_cnt_s     = bit_cnt_r;
        par_s         = par_r;
        status_s      = status_r;
        dx_s          = dx_r;
        tmo_cnt_s     = tmo_cnt_r;
        xpos_s        = xpos_r;
        ypos_s        = ypos_r;
        left_s        = left_r;
        right_s       = right_r;
        pkt_valid_s   = 1'b0;
        err_s         = 1'b0;
        nx_s = $signed({1'b0, xpos_r}) + sext_delta(status_r[2], status_r[4], dx_r);
        ny_s = $signed({1'b0, ypos_r}) - sext_delta(status_r[3], status_r[5], shift_r);

        if (fall_r) begin
            tmo_cnt_s = '0;
            case (frame_state_r)
                F_IDLE: begin
                    if (!bit_r) begin
                        frame_state_s = F_DATA;
                        bit_cnt_s     = 3'd0;
                    end else begin
                        frame_state_s = F_IDLE;
                    end
                end
                F_DATA: begin
                    shift_s   = {bit_r, shift_r[7:1]};
                    bit_cnt_s = bit_cnt_r + 3'd1;
                    if (bit_cnt_r == 3'd7) frame_state_s = F_PARITY;
                    else                   frame_state_s = F_DATA;
                end
                F_PARITY: begin
                    par_s         = bit_r;
                    frame_state_s = F_STOP;
                end
                F_STOP: begin
                    frame_state_s = F_IDLE;
                    if (bit_r && frame_parity_ok(shift_r, par_r)) begin
                        case (pkt_state_r)
                            P_B0: begin
                                if (shift_r[3]) begin
                                    status_s    = {shift_r[7:4], shift_r[1:0]};
                                    pkt_state_s = P_B1;
                                end else begin
                                    err_s = 1'b1;
                                end
                            end
                            P_B1: begin
                                dx_s        = shift_r;
                                pkt_state_s = P_B2;
                            end
                            P_B2: begin
                                xpos_s      = clamp_axis(nx_s, XMAX_C);
                                ypos_s      = clamp_axis(ny_s, YMAX_C);
                                left_s      = status_r[0];
                                right_s     = status_r[1];
                                pkt_valid_s = 1'b1;
                                pkt_state_s = P_B0;
                            end
                            default: pkt_state_s = P_B0;
                        endcase
                    end else begin
                        err_s       = 1'b1;
                        pkt_state_s = P_B0;
                    end
                end
                default: frame_state_s = F_IDLE;
            endcase
        end else if (frame_state_r != F_IDLE || pkt_state_r != P_B0) begin
            if (tmo_cnt_r >= TMO_LAST) begin
                tmo_cnt_s     = '0;
                frame_state_s = F_IDLE;
                pkt_state_s   = P_B0;
                err_s         = 1'b1;
            end else begin
                tmo_cnt_s = tmo_cnt_r + TW'(1);
            end
        end else begin
            tmo_cnt_s = '0;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_state_r <= F_IDLE;
            pkt_state_r   <= P_B0;
            shift_r       <= 8'd0;
            bit_cnt_r     <= 3'd0;
            par_r         <= 1'b0;
            status_r      <= 6'd0;
            dx_r          <= 8'd0;
            tmo_cnt_r     <= '0;
            xpos_r        <= X_INIT_C;
            ypos_r        <= Y_INIT_C;
            left_r        <= 1'b0;
            right_r       <= 1'b0;
            pkt_valid_r   <= 1'b0;
            err_r         <= 1'b0;
        end else begin
            frame_state_r <= frame_state_s;
            pkt_state_r   <= pkt_state_s;
            shift_r       <= shift_s;
            bit_cnt_r     <= bit_cnt_s;
            par_r         <= par_s;
            status_r      <= status_s;
            dx_r          <= dx_s;
            tmo_cnt_r     <= tmo_cnt_s;
            xpos_r        <= xpos_s;
            ypos_r        <= ypos_s;
            left_r        <= left_s;
            right_r       <= right_s;
            pkt_valid_r   <= pkt_valid_s;
            err_r         <= err_s;
        end
    end

    assign bus.xpos        = xpos_r;
    assign bus.ypos        = ypos_r;
    assign bus.mouse_left  = left_r;
    assign bus.mouse_right = right_r;
    assign bus.pkt_valid   = pkt_valid_r;
    assign bus.err         = err_r;

endmodule

// File: tb/tb_ps2_mouse_rx.sv
// Directed bench for ps2_mouse_rx: drives PS/2 frames bit by bit and checks
// cursor, buttons and pulse counts against hand-computed values.
module tb_ps2_mouse_rx;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ps2_mouse_rx_if bus ();

    ps2_mouse_rx #(
        .XMAX(1023), .YMAX(767), .X_INIT(512), .Y_INIT(384), .TIMEOUT(300)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_assert = 0;
    int n_fail   = 0;
    int err_hi   = 0;
    int pv_hi    = 0;
    int e0, p0, lat;

    // Count clock cycles during which each pulse output is high.
    always @(posedge clk) begin
        if (bus.err === 1'b1)       err_hi <= err_hi + 1;
        if (bus.pkt_valid === 1'b1) pv_hi  <= pv_hi + 1;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic ps2_bit(input logic b);
        bus.ps2_data = b;
        wait_cyc(8);
        bus.ps2_clk = 1'b0;
        wait_cyc(8);
        bus.ps2_clk = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic bad_par);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(d[i]);
        ps2_bit((~^d) ^ bad_par);
        ps2_bit(1'b1);
        wait_cyc(10);
    endtask

    // Last byte of a packet; measures negedges from the stop-bit fall to pkt_valid.
    task automatic send_last(input logic [7:0] d, output int l);
        l = -1;
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(d[i]);
        ps2_bit(~^d);
        bus.ps2_data = 1'b1;
        wait_cyc(8);
        bus.ps2_clk = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (l < 0 && bus.pkt_valid === 1'b1) l = k;
        end
        bus.ps2_clk = 1'b1;
        wait_cyc(10);
    endtask

    task automatic send_pkt(input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2, output int l);
        send_byte(b0, 1'b0);
        send_byte(b1, 1'b0);
        send_last(b2, l);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        bus.ps2_clk  = 1'b1;
        bus.ps2_data = 1'b1;
        wait_cyc(5);
        rst = 1'b1;
        wait_cyc(5);
    endtask

    initial begin
        bus.ps2_clk  = 1'b1;
        bus.ps2_data = 1'b1;
        rst = 1'b0;
        wait_cyc(5);
        chk("rst_xpos_held", bus.xpos, 512);
        chk("rst_ypos_held", bus.ypos, 384);
        rst = 1'b1;
        e0 = err_hi; p0 = pv_hi;
        wait_cyc(1000);
        chk("rst_xpos", bus.xpos, 512);
        chk("rst_ypos", bus.ypos, 384);
        chk("rst_left", bus.mouse_left, 0);
        chk("rst_right", bus.mouse_right, 0);
        chk("rst_no_err", err_hi - e0, 0);
        chk("rst_no_pv", pv_hi - p0, 0);

        // Basic packet: left button, dx = +16, dy = +5 (screen up by 5).
        p0 = pv_hi;
        send_pkt(8'h09, 8'h10, 8'h05, lat);
        chk("basic_left", bus.mouse_left, 1);
        chk("basic_xpos", bus.xpos, 528);
        chk("basic_ypos", bus.ypos, 379);
        chk("basic_pv_once", pv_hi - p0, 1);
        chk("basic_pv_latency", (lat >= 3 && lat <= 5), 1);

        // Clamping: dx = dy = -256 three times.
        do_reset();
        send_pkt(8'h38, 8'h00, 8'h00, lat);
        chk("clamp1_x", bus.xpos, 256);
        chk("clamp1_y", bus.ypos, 640);
        send_pkt(8'h38, 8'h00, 8'h00, lat);
        chk("clamp2_x", bus.xpos, 0);
        chk("clamp2_y", bus.ypos, 767);
        send_pkt(8'h38, 8'h00, 8'h00, lat);
        chk("clamp3_x", bus.xpos, 0);
        chk("clamp3_y", bus.ypos, 767);

        // Parity error on byte 1 discards the packet.
        do_reset();
        e0 = err_hi; p0 = pv_hi;
        send_byte(8'h09, 1'b0);
        send_byte(8'h10, 1'b1);
        chk("par_err_once", err_hi - e0, 1);
        chk("par_no_pv", pv_hi - p0, 0);
        chk("par_xpos", bus.xpos, 512);
        chk("par_ypos", bus.ypos, 384);
        chk("par_left", bus.mouse_left, 0);
        send_pkt(8'h0A, 8'h01, 8'h00, lat);
        chk("par_next_right", bus.mouse_right, 1);
        chk("par_next_left", bus.mouse_left, 0);
        chk("par_next_xpos", bus.xpos, 513);

        // Sync loss: a byte without bit3 is dropped in B0.
        do_reset();
        e0 = err_hi;
        send_byte(8'h01, 1'b0);
        chk("sync_err_once", err_hi - e0, 1);
        send_pkt(8'h08, 8'hFF, 8'h00, lat);
        chk("sync_xpos", bus.xpos, 767);
        chk("sync_ypos", bus.ypos, 384);
        chk("sync_err_total", err_hi - e0, 1);

        // Timeout inside a packet: byte 0 plus start and three data bits.
        do_reset();
        e0 = err_hi;
        send_byte(8'h08, 1'b0);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        wait_cyc(310);
        chk("tmo_err_once", err_hi - e0, 1);
        send_pkt(8'h08, 8'h02, 8'h02, lat);
        chk("tmo_xpos", bus.xpos, 514);
        chk("tmo_ypos", bus.ypos, 382);
        chk("tmo_err_total", err_hi - e0, 1);

        // Reset mid-byte abandons the partial frame silently.
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b1);
        e0 = err_hi;
        rst = 1'b0;
        wait_cyc(2);
        chk("midrst_xpos", bus.xpos, 512);
        chk("midrst_ypos", bus.ypos, 384);
        rst = 1'b1;
        wait_cyc(20);
        chk("midrst_no_err", err_hi - e0, 0);
        chk("midrst_left", bus.mouse_left, 0);
        p0 = pv_hi;
        send_pkt(8'h09, 8'h00, 8'h00, lat);
        chk("midrst_next_left", bus.mouse_left, 1);
        chk("midrst_next_xpos", bus.xpos, 512);
        chk("midrst_next_pv", pv_hi - p0, 1);
        chk("midrst_next_no_err", err_hi - e0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/ps2_mouse_rx.md
# ps2_mouse_rx

Receive-only PS/2 mouse front end: it samples the raw `ps2_clk`/`ps2_data` lines, deframes 11-bit device-to-host frames, assembles 3-byte standard mouse packets, and accumulates a clamped absolute cursor position. Its outputs drive the `xpos`, `ypos` and `mouse_left` inputs of the menu/game top-level controller. Stream-mode enabling (host command 0xF4) is done by the separate mouse init block, so this block never drives the PS/2 lines.

## Interface
Parameters:
- `XMAX`, 1023: largest legal `xpos`.
- `YMAX`, 767: largest legal `ypos`.
- `X_INIT`, 512: `xpos` reset value.
- `Y_INIT`, 384: `ypos` reset value.
- `TIMEOUT`, 65000: idle clk cycles tolerated inside an unfinished packet.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-low reset.
- `ps2_clk`  in  1  raw PS/2 clock, asynchronous to `clk`.
- `ps2_data`  in  1  raw PS/2 data, asynchronous to `clk`.
- `xpos`  out  12  cursor X, range 0..XMAX.
- `ypos`  out  12  cursor Y, range 0..YMAX, increasing downward.
- `mouse_left`  out  1  left button state from the last accepted packet.
- `mouse_right`  out  1  right button state from the last accepted packet.
- `pkt_valid`  out  1  one-cycle pulse when a packet is applied.
- `err`  out  1  one-cycle pulse on any discarded frame or packet.

## Operation
- Both PS/2 inputs pass through 2-FF synchronizers. A falling edge is detected on the synchronized `ps2_clk`, and `ps2_data` is sampled on that edge.
- Frame FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: a sampled 0 is a start bit and moves to DATA. A sampled 1 stays in IDLE.
  - DATA: shifts 8 bits LSB first, using a 3-bit counter, then moves to PARITY.
  - PARITY: stores the bit. The frame is good when data XOR parity has odd parity (odd number of ones).
  - STOP: the bit must be 1. A good frame emits the byte internally, and the FSM always returns to IDLE.
- Packet FSM states: B0, B1, B2.
  - B0 accepts a byte only if bit3 = 1 and stores the status byte. A byte with bit3 = 0 is dropped, `err` pulses and the FSM stays in B0.
  - B1 stores dx[7:0]. B2 stores dy[7:0] and triggers the update.
- Status byte fields: bit0 = left, bit1 = right, bit4 = X sign, bit5 = Y sign, bit6 = X overflow, bit7 = Y overflow.
- Update arithmetic:
  - dx = {Xsign, byte1} as 9-bit signed. dy = {Ysign, byte2} likewise.
  - X axis: 13-bit signed nx = xpos + sext(dx). If nx < 0, xpos = 0. If nx > XMAX, xpos = XMAX. Otherwise xpos = nx.
  - Y axis: ny = ypos − sext(dy), clamped to 0..YMAX the same way. PS/2 +Y is up; screen +Y is down.
  - If an axis overflow bit is set, that axis delta is treated as 0. The buttons and the other axis still update.
- Parity error or stop bit = 0 in any byte: the frame is discarded, `err` pulses, the packet FSM returns to B0 and outputs are unchanged.
- Timeout: a counter runs while the frame FSM is not IDLE or the packet FSM is not B0, and clears on every ps2_clk falling edge. When it reaches TIMEOUT, both FSMs return to IDLE/B0 and `err` pulses once.
- Simultaneous events: a sampled edge and a timeout in the same cycle are resolved in favour of the edge, and the counter clears.

## Timing
- Reset (`rst` = 0, asynchronous): the FSMs go to IDLE/B0, counters clear, synchronizers go to 1. Outputs reset to `xpos` = X_INIT, `ypos` = Y_INIT, buttons 0, `pkt_valid` 0, `err` 0.
- Reset mid-frame or mid-packet abandons all partial data with no `err` pulse.
- Edge latency: a raw `ps2_clk` fall is acted on 3 clk cycles later (2 synchronizer stages plus the edge register).
- Packet application: `xpos`, `ypos` and the buttons update in the clk cycle after the byte-2 stop bit is sampled. `pkt_valid` is high in that same cycle, for exactly one cycle.
- `err` is high for exactly one cycle, the cycle after the offending sample or timeout.
- All outputs are registered and hold their value between packets.

## Test plan
- Reset: hold `rst` = 0, then release with idle lines → `xpos` = 512, `ypos` = 384, `mouse_left` = 0, no pulses for 1000 cycles.
- Basic packet 0x09, 0x10, 0x05 → `mouse_left` = 1, `xpos` = 528, `ypos` = 379, a single `pkt_valid` pulse 1 cycle after the last stop bit.
- Clamping: three packets 0x38, 0x00, 0x00 (dx = −256, dy = −256) → `xpos` 256, 0, 0 and `ypos` 640, 767, 767.
- Parity error: byte 1 is sent with bad parity → `err` pulses once, outputs unchanged. The next good packet 0x0A, 0x01, 0x00 gives `mouse_right` = 1 and `xpos` = 513.
- Sync loss: a lone byte 0x01 (bit3 = 0) followed by packet 0x08, 0xFF, 0x00 with Xsign = 0 → `err` pulses once, then `xpos` = 767.
- Timeout and reset mid-frame:
  - Send byte 0 plus 4 bits, stall TIMEOUT + 10 cycles → exactly one `err` pulse. A following packet 0x08, 0x02, 0x02 gives `xpos` 514, `ypos` 382.
  - Assert `rst` mid-byte → outputs return to reset values with no `err` pulse.
